// File: rtl/cp0_pkg.sv
// Shared constants and the exception decoder for the CP0 register block.
package cp0_pkg;

    localparam logic [4:0] RegBadVAddr = 5'd8;
    localparam logic [4:0] RegCount    = 5'd9;
    localparam logic [4:0] RegCompare  = 5'd11;
    localparam logic [4:0] RegStatus   = 5'd12;
    localparam logic [4:0] RegCause    = 5'd13;
    localparam logic [4:0] RegEpc      = 5'd14;
    localparam logic [4:0] RegPrid     = 5'd15;

    localparam logic [31:0] ExcTypeInt  = 32'h0000_0001;
    localparam logic [31:0] ExcTypeAdel = 32'h0000_0004;
    localparam logic [31:0] ExcTypeAdes = 32'h0000_0005;
    localparam logic [31:0] ExcTypeSys  = 32'h0000_0008;
    localparam logic [31:0] ExcTypeBp   = 32'h0000_0009;
    localparam logic [31:0] ExcTypeRi   = 32'h0000_000a;
    localparam logic [31:0] ExcTypeOv   = 32'h0000_000c;
    localparam logic [31:0] ExcTypeEret = 32'h0000_000e;

    localparam logic [4:0] ExcCodeInt  = 5'h00;
    localparam logic [4:0] ExcCodeAdel = 5'h04;
    localparam logic [4:0] ExcCodeAdes = 5'h05;
    localparam logic [4:0] ExcCodeSys  = 5'h08;
    localparam logic [4:0] ExcCodeBp   = 5'h09;
    localparam logic [4:0] ExcCodeRi   = 5'h0a;
    localparam logic [4:0] ExcCodeOv   = 5'h0c;

    localparam logic [31:0] ExcVector   = 32'hBFC0_0380;
    localparam logic [31:0] PridValue   = 32'h0000_4220;
    localparam logic [31:0] StatusReset = 32'h0040_0000;

    typedef enum logic [1:0] {
        ExcNone,
        ExcTrap,
        ExcReturn
    } exc_kind_e;

    typedef struct packed {
        exc_kind_e  kind;
        logic [4:0] code;
        logic       bad_addr;
    } exc_dec_t;

    function automatic exc_dec_t exc_decode(input logic [31:0] exc_type);
        exc_dec_t dec;
        dec = '{kind: ExcTrap, code: ExcCodeInt, bad_addr: 1'b0};
        case (exc_type)
            ExcTypeInt:  dec.code = ExcCodeInt;
            ExcTypeAdel: begin dec.code = ExcCodeAdel; dec.bad_addr = 1'b1; end
            ExcTypeAdes: begin dec.code = ExcCodeAdes; dec.bad_addr = 1'b1; end
            ExcTypeSys:  dec.code = ExcCodeSys;
            ExcTypeBp:   dec.code = ExcCodeBp;
            ExcTypeRi:   dec.code = ExcCodeRi;
            ExcTypeOv:   dec.code = ExcCodeOv;
            ExcTypeEret: dec.kind = ExcReturn;
            default:     dec.kind = ExcNone;
        endcase
        return dec;
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare pair: Count ticks every second cycle, timer interrupt on match.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        toggle_q, toggle_d;
    logic        timer_int_q, timer_int_d;

    always_comb begin
        toggle_d    = ~toggle_q;
        count_d     = toggle_q ? count_q + 32'd1 : count_q;
        compare_d   = compare_q;
        timer_int_d = timer_int_q;

        if (compare_q != 32'd0 && count_q == compare_q) begin
            timer_int_d = 1'b1;
        end

        if (we_i && waddr_i == RegCount) begin
            count_d  = wdata_i;
            toggle_d = 1'b0;
        end
        // A Compare write acknowledges the interrupt, even on a match cycle.
        if (we_i && waddr_i == RegCompare) begin
            compare_d   = wdata_i;
            timer_int_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q     <= 32'd0;
            compare_q   <= 32'd0;
            toggle_q    <= 1'b0;
            timer_int_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            compare_q   <= compare_d;
            toggle_q    <= toggle_d;
            timer_int_q <= timer_int_d;
        end
    end

    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = timer_int_q;

endmodule

// File: rtl/cp0_reg.sv
// CP0 system-control registers: Status, Cause, EPC, BadVAddr, exception entry and ERET.
module cp0_reg
    import cp0_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] exception_type_i,
    input  logic [31:0] current_pc_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] rdata_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic [31:0] badvaddr_o,
    output logic        timer_int_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    logic [7:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [1:0]  sw_q, sw_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;

    exc_dec_t exc_dec;
    logic     exc_take;
    logic     eret_take;

    cp0_timer u_timer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .we_i        (we_i),
        .waddr_i     (waddr_i),
        .wdata_i     (wdata_i),
        .count_o     (count_o),
        .compare_o   (compare_o),
        .timer_int_o (timer_int_o)
    );

    assign exc_dec   = exc_decode(exception_type_i);
    assign exc_take  = !rst_i && exc_dec.kind == ExcTrap;
    assign eret_take = !rst_i && exc_dec.kind == ExcReturn;

    always_comb begin
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        sw_d       = sw_q;
        exccode_d  = exccode_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        ip_d       = {int_i[5] | timer_int_o, int_i[4:0]};

        if (eret_take) begin
            exl_d = 1'b0;
        end else if (exc_take) begin
            // Nested exceptions keep the original return point.
            if (!exl_q) begin
                epc_d = is_in_delayslot_i ? current_pc_i - 32'd4 : current_pc_i;
                bd_d  = is_in_delayslot_i;
            end
            exl_d     = 1'b1;
            exccode_d = exc_dec.code;
            if (exc_dec.bad_addr) begin
                badvaddr_d = bad_addr_i;
            end
        end else if (we_i) begin
            case (waddr_i)
                RegStatus: begin
                    im_d  = wdata_i[15:8];
                    exl_d = wdata_i[1];
                    ie_d  = wdata_i[0];
                end
                RegCause: sw_d  = wdata_i[9:8];
                RegEpc:   epc_d = wdata_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            sw_q       <= 2'd0;
            exccode_q  <= 5'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
        end else begin
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            sw_q       <= sw_d;
            exccode_q  <= exccode_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end

    assign status_o   = StatusReset | {16'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_o    = {bd_q, 15'd0, ip_q, sw_q, 1'b0, exccode_q, 2'b00};
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;

    assign flush_o = exc_take || eret_take;

    always_comb begin
        new_pc_o = 32'd0;
        if (exc_take) begin
            new_pc_o = ExcVector;
        end else if (eret_take) begin
            // Forward a same-cycle EPC write so ERET returns where software intended.
            new_pc_o = (we_i && waddr_i == RegEpc) ? wdata_i : epc_q;
        end
    end

    always_comb begin
        rdata_o = 32'd0;
        case (raddr_i)
            RegBadVAddr: rdata_o = badvaddr_q;
            RegCount:    rdata_o = count_o;
            RegCompare:  rdata_o = compare_o;
            RegStatus:   rdata_o = status_o;
            RegCause:    rdata_o = cause_o;
            RegEpc:      rdata_o = epc_q;
            RegPrid:     rdata_o = PridValue;
            default:     rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_reg.sv
// Bench for cp0_reg: behavioural CP0 model checked every cycle plus directed literal checks.
module tb_cp0_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [5:0]  int_in;
    logic [31:0] et;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] rdata_o, status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o, new_pc_o;
    logic        timer_int_o, flush_o;

    int n_vec  = 0;
    int n_fail = 0;
    bit check_en = 1'b0;

    always #5 clk = ~clk;

    cp0_reg dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .we_i              (we),
        .waddr_i           (waddr),
        .wdata_i           (wdata),
        .raddr_i           (raddr),
        .int_i             (int_in),
        .exception_type_i  (et),
        .current_pc_i      (pc),
        .is_in_delayslot_i (ds),
        .bad_addr_i        (bad),
        .rdata_o           (rdata_o),
        .status_o          (status_o),
        .cause_o           (cause_o),
        .epc_o             (epc_o),
        .count_o           (count_o),
        .compare_o         (compare_o),
        .badvaddr_o        (badvaddr_o),
        .timer_int_o       (timer_int_o),
        .flush_o           (flush_o),
        .new_pc_o          (new_pc_o)
    );

    // Model state, kept as architectural fields rather than raw register images.
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_tint;
    logic [5:0]  m_ip;
    logic [1:0]  m_sw;
    logic [4:0]  m_exc;
    logic [31:0] m_epc, m_bad, m_cmp, m_cnt_base;
    int unsigned m_half;

    function automatic bit is_valid(input logic [31:0] t);
        return t == 32'h01 || t == 32'h04 || t == 32'h05 || t == 32'h08 ||
               t == 32'h09 || t == 32'h0a || t == 32'h0c || t == 32'h0e;
    endfunction

    function automatic logic [4:0] code_of(input logic [31:0] t);
        return (t == 32'h01) ? 5'd0 : t[4:0];
    endfunction

    // Count is the value loaded plus half the cycles elapsed since the load.
    function automatic logic [31:0] m_count();
        return m_cnt_base + 32'(m_half / 2);
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | (32'(m_im) << 8) | (32'(m_exl) << 1) | 32'(m_ie);
    endfunction

    function automatic logic [31:0] m_cause();
        return (32'(m_bd) << 31) | (32'(m_ip) << 10) | (32'(m_sw) << 8) | (32'(m_exc) << 2);
    endfunction

    function automatic logic [31:0] m_new_pc();
        if (rst || !is_valid(et)) return 32'd0;
        if (et == 32'h0e) return (we && waddr == 5'd14) ? wdata : m_epc;
        return 32'hBFC0_0380;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count();
            5'd11:   return m_cmp;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_4220;
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_im <= '0; m_exl <= 0; m_ie <= 0; m_bd <= 0; m_tint <= 0; m_ip <= '0;
            m_sw <= '0; m_exc <= '0; m_epc <= '0; m_bad <= '0; m_cmp <= '0;
            m_cnt_base <= '0; m_half <= 0;
        end else begin
            m_half <= m_half + 1;
            m_ip   <= {int_in[5] | m_tint, int_in[4:0]};
            if (we && waddr == 5'd9) begin
                m_cnt_base <= wdata;
                m_half     <= 0;
            end
            if (we && waddr == 5'd11) begin
                m_cmp  <= wdata;
                m_tint <= 1'b0;
            end else if (m_cmp != 0 && m_count() == m_cmp) begin
                m_tint <= 1'b1;
            end
            if (et == 32'h0e) begin
                m_exl <= 1'b0;
            end else if (is_valid(et)) begin
                if (!m_exl) begin
                    m_epc <= ds ? pc - 32'd4 : pc;
                    m_bd  <= ds;
                end
                m_exl <= 1'b1;
                m_exc <= code_of(et);
                if (et == 32'h04 || et == 32'h05) m_bad <= bad;
            end else if (we && waddr == 5'd12) begin
                m_im  <= wdata[15:8];
                m_exl <= wdata[1];
                m_ie  <= wdata[0];
            end else if (we && waddr == 5'd13) begin
                m_sw <= wdata[9:8];
            end else if (we && waddr == 5'd14) begin
                m_epc <= wdata;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("m_status",   status_o,    m_status());
            chk("m_cause",    cause_o,     m_cause());
            chk("m_epc",      epc_o,       m_epc);
            chk("m_count",    count_o,     m_count());
            chk("m_compare",  compare_o,   m_cmp);
            chk("m_badvaddr", badvaddr_o,  m_bad);
            chk("m_timer",    32'(timer_int_o), 32'(m_tint));
            chk("m_flush",    32'(flush_o), 32'(!rst && is_valid(et)));
            chk("m_new_pc",   new_pc_o,    m_new_pc());
            chk("m_rdata",    rdata_o,     m_rdata(raddr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        raddr = raddr + 5'd1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
    endtask

    initial begin
        int edges;
        rst = 1; we = 0; waddr = 0; wdata = 0; raddr = 0; int_in = 0;
        et = 0; pc = 0; ds = 0; bad = 0;
        step();
        check_en = 1'b1;
        step();
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'd0);
        chk("rst_count", count_o, 32'd0);
        rst = 0;

        // Timer: Count=0, then Compare=10; interrupt expected 21 edges after the Count load.
        mtc0(5'd9, 32'd0);   step();
        mtc0(5'd11, 32'd10); step();
        we = 0;
        edges = 1;
        for (int i = 0; i < 40 && !timer_int_o; i++) begin
            step();
            edges++;
        end
        chk("timer_rise", 32'(timer_int_o), 32'd1);
        chk("timer_edge", 32'(edges), 32'd21);
        step();
        chk("cause_ip7", 32'(cause_o[15]), 32'd1);
        mtc0(5'd11, 32'd0); step(); we = 0;
        chk("timer_clr", 32'(timer_int_o), 32'd0);

        // Syscall.
        et = 32'h08; pc = 32'hBFC0_0100; ds = 0; #1;
        chk("sys_flush", 32'(flush_o), 32'd1);
        chk("sys_newpc", new_pc_o, 32'hBFC0_0380);
        step(); et = 0;
        chk("sys_epc", epc_o, 32'hBFC0_0100);
        chk("sys_code", 32'(cause_o[6:2]), 32'd8);
        chk("sys_exl", 32'(status_o[1]), 32'd1);

        et = 32'h0e; #1;
        chk("eret1_newpc", new_pc_o, 32'hBFC0_0100);
        step(); et = 0;
        chk("eret1_exl", 32'(status_o[1]), 32'd0);

        // Delay-slot overflow, then a nested RI with EXL set.
        et = 32'h0c; pc = 32'h8000_0024; ds = 1; step(); et = 0; ds = 0;
        chk("ds_epc", epc_o, 32'h8000_0020);
        chk("ds_bd", 32'(cause_o[31]), 32'd1);
        et = 32'h0a; pc = 32'h8000_0100; step(); et = 0;
        chk("nest_epc", epc_o, 32'h8000_0020);
        chk("nest_code", 32'(cause_o[6:2]), 32'd10);

        // ERET return targets, plus same-cycle EPC write forwarding.
        mtc0(5'd14, 32'h8000_1000); step(); we = 0;
        et = 32'h0e; #1;
        chk("eret2_newpc", new_pc_o, 32'h8000_1000);
        step(); et = 0;
        chk("eret2_exl", 32'(status_o[1]), 32'd0);
        et = 32'h0e; mtc0(5'd14, 32'h8000_2000); #1;
        chk("eret3_newpc", new_pc_o, 32'h8000_2000);
        step(); et = 0; we = 0;
        chk("eret3_epc", epc_o, 32'h8000_1000);

        // Status write colliding with AdEL.
        mtc0(5'd12, 32'h0000_FF01); et = 32'h04; bad = 32'h1235; pc = 32'h8000_0300;
        step(); we = 0; et = 0;
        chk("coll_status", status_o, 32'h0040_0002);
        chk("coll_bad", badvaddr_o, 32'h0000_1235);

        // Unknown code, register write masks, PRId.
        et = 32'h02; #1;
        chk("bad_code_flush", 32'(flush_o), 32'd0);
        chk("bad_code_newpc", new_pc_o, 32'd0);
        et = 0;
        mtc0(5'd12, 32'hFFFF_FFFF); step(); we = 0;
        chk("status_mask", status_o, 32'h0040_FF03);
        int_in = 6'h15; mtc0(5'd13, 32'hFFFF_FFFF); step(); we = 0;
        chk("cause_mask", cause_o, 32'h0000_5710);
        mtc0(5'd8, 32'hDEAD_BEEF); step(); we = 0;
        chk("bad_ro", badvaddr_o, 32'h0000_1235);
        raddr = 5'd15; #1;
        chk("prid", rdata_o, 32'h0000_4220);

        // Reset mid-count with a write and an exception pending.
        rst = 1; mtc0(5'd12, 32'h0000_FFFF); et = 32'h08; #1;
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_newpc", new_pc_o, 32'd0);
        step(); rst = 0; we = 0; et = 0; int_in = 0;
        chk("rst2_status", status_o, 32'h0040_0000);
        chk("rst2_count", count_o, 32'd0);
        chk("rst2_epc", epc_o, 32'd0);
        chk("rst2_cause", cause_o, 32'd0);
        chk("rst2_bad", badvaddr_o, 32'd0);
        for (int i = 0; i < 6; i++) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
CP0_REG -- requirements
Module: cp0_reg

Interface
REQ-001 SHALL have ports: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-002 SHALL have ports: we_i  in  1  mtc0 write enable; waddr_i  in  5  write register number; wdata_i  in  32  write data; raddr_i  in  5  mfc0 read register number.
REQ-003 SHALL have ports: int_i  in  6  external hardware interrupts; exception_type_i  in  32  prioritized exception code; current_pc_i  in  32  PC of excepting instruction; is_in_delayslot_i  in  1  instruction is in a delay slot; bad_addr_i  in  32  faulting address.
REQ-004 SHALL have ports: rdata_o  out  32  read data; status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o  out  32 each  register values; timer_int_o  out  1  timer interrupt pending; flush_o  out  1  pipeline flush; new_pc_o  out  32  redirect target.

Function
REQ-005 SHALL decode exception_type_i codes: 0x01 interrupt (ExcCode 0), 0x04 AdEL, 0x05 AdES, 0x08 Sys, 0x09 Bp, 0x0a RI, 0x0c Ov, 0x0e ERET; any other nonzero value is treated as no exception.
REQ-006 SHALL implement Count (9): increments by 1 every second cycle using an internal toggle bit, wrapping 0xFFFFFFFF->0; an mtc0 write loads wdata_i and clears the toggle.
REQ-007 SHALL implement Compare (11): an mtc0 write loads wdata_i and clears timer_int_o in the same edge.
REQ-008 SHALL set timer_int_o on the edge after Count==Compare with Compare!=0; it holds until a Compare write or reset.
REQ-009 SHALL sample Cause[15:10] every cycle as int_i[5:0], with Cause[15] = int_i[5] OR timer_int_o; Cause[9:8] are mtc0-writable only; Cause[31] is BD; Cause[6:2] is ExcCode; all other Cause bits read 0.
REQ-010 SHALL make Status (12) writable only at bits [15:8] IM, [1] EXL, [0] IE; bit 22 BEV is constant 1; all other bits read 0.
REQ-011 SHALL, on a non-ERET exception: if Status.EXL==0, set EPC = current_pc_i-4 and Cause.BD=1 when is_in_delayslot_i, else EPC = current_pc_i and BD=0; if EXL==1, leave EPC and BD unchanged. In both cases it SHALL set EXL=1 and write ExcCode.
REQ-012 SHALL, for AdEL/AdES, load BadVAddr (8) from bad_addr_i; BadVAddr SHALL not be mtc0-writable.
REQ-013 SHALL, on ERET, clear Status.EXL and leave all other registers unchanged.
REQ-014 SHALL give a same-cycle exception or ERET priority over an mtc0 write to Status, Cause or EPC; the write to those registers is dropped and writes to other registers proceed.
REQ-015 SHALL drive flush_o combinationally high whenever a valid code is present on exception_type_i.
REQ-016 SHALL drive new_pc_o combinationally: 0xBFC00380 for exceptions; for ERET, the current EPC, or wdata_i when an mtc0 write to EPC occurs in the same cycle.
REQ-017 SHALL drive rdata_o combinationally from the registered values: PRId (15) = 0x00004220 constant; unimplemented numbers read 0.

Reset
REQ-018 SHALL, on rst_i high at a clock edge, set: Status=0x00400000; Cause, EPC, Count, Compare, BadVAddr, the toggle bit and timer_int_o = 0.
REQ-019 SHALL, while rst_i is high, ignore mtc0 writes and exceptions; flush_o SHALL be 0 and new_pc_o SHALL be 0.

Structure
REQ-020 SHALL place the following in shared package cp0_pkg: CP0 register number constants, exception_type code constants, ExcCode constants, the exception vector 0xBFC00380 and the PRId value.
REQ-021 SHALL implement Count/Compare/timer_int as sub-module cp0_timer; all other registers SHALL be implemented in cp0_reg.

Verification
REQ-022 SHALL cover timer: write Compare=10 after reset -> timer_int_o rises at cycle ~21 and Cause[15]=1; write Compare=0 -> timer_int_o clears on the next edge.
REQ-023 SHALL cover syscall: exception_type_i=0x08, pc=0xBFC00100, delayslot=0 -> EPC=0xBFC00100, ExcCode=8, EXL=1, flush_o=1, new_pc_o=0xBFC00380.
REQ-024 SHALL cover delay slot: exception_type_i=0x0c, pc=0x80000024, delayslot=1 -> EPC=0x80000020, BD=1; a nested exception with EXL=1 -> EPC unchanged.
REQ-025 SHALL cover ERET: with EPC=0x80001000, exception_type_i=0x0e -> new_pc_o=0x80001000 and EXL=0; ERET in the same cycle as mtc0 EPC=0x80002000 -> new_pc_o=0x80002000.
REQ-026 SHALL cover collision/reset: mtc0 Status=0xFF01 in the same cycle as AdEL (bad_addr=0x1235) -> Status write dropped, EXL=1, BadVAddr=0x1235; asserting rst_i mid-count -> all registers return to reset values.
